// File: rtl/rocev2_top_hls_deadlock_report_ctrl.sv
// Deadlock report controller: picks a suspect process, circulates the confirmation
// token and latches a sticky report after enough consecutive token round trips.
module rocev2_top_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int IDX_W          = 2,
    parameter int CONFIRM_ROUNDS = 4,
    parameter int TIMEOUT        = 64
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic                clear_report,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    output logic                deadlock_found,
    output logic [IDX_W-1:0]    deadlock_idx,
    output logic                report_valid
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ORIGIN = 2'd1,
        S_WAIT   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [3:0] RND_TARGET = 4'(CONFIRM_ROUNDS);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] TMO_SAT    = 8'(TIMEOUT);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [3:0]       r_rounds;
    logic [7:0]       r_tmo;
    logic             r_found;
    logic [IDX_W-1:0] r_dl_idx;
    logic             r_report_valid;

    logic             w_any;
    logic [IDX_W-1:0] w_lowest;
    logic             w_return;

    assign w_any    = |dl_detect_vec;
    assign w_return = dl_detect_vec[r_idx];

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        w_lowest = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_detect_vec[i]) w_lowest = IDX_W'(i);
        end
    end

    assign dl_detect_in   = (r_state != S_IDLE);
    // Must be combinational: units expect the kill in the same cycle the token arrives.
    assign token_clear    = (r_state == S_WAIT) && w_return;
    assign deadlock_found = r_found;
    assign deadlock_idx   = r_dl_idx;
    assign report_valid   = r_report_valid;

    genvar gi;
    generate
        for (gi = 0; gi < PROC_NUM; gi++) begin : g_origin
            assign origin_vec[gi] = (r_state == S_ORIGIN) && (r_idx == IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_rounds       <= '0;
            r_tmo          <= '0;
            r_found        <= 1'b0;
            r_dl_idx       <= '0;
            r_report_valid <= 1'b0;
        end else begin
            r_report_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_idx    <= w_lowest;
                        r_rounds <= '0;
                        r_state  <= S_ORIGIN;
                    end
                end
                S_ORIGIN: begin
                    r_tmo   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_tmo != TMO_SAT) r_tmo <= r_tmo + 8'd1;
                    // A return on the final timeout cycle still counts as a round.
                    if (w_return) begin
                        if ((r_rounds + 4'd1) == RND_TARGET) begin
                            r_dl_idx       <= r_idx;
                            r_found        <= 1'b1;
                            r_report_valid <= 1'b1;
                            r_state        <= S_REPORT;
                        end else begin
                            r_rounds <= r_rounds + 4'd1;
                            r_state  <= S_ORIGIN;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_rounds <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                S_REPORT: begin
                    if (clear_report) begin
                        r_found  <= 1'b0;
                        r_dl_idx <= '0;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rocev2_top_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller (PROC_NUM=4, CONFIRM_ROUNDS=4, TIMEOUT=64).
module tb_rocev2_top_hls_deadlock_report_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] dl_detect_vec;
    logic       clear_report;
    logic       dl_detect_in;
    logic [3:0] origin_vec;
    logic       token_clear;
    logic       deadlock_found;
    logic [1:0] deadlock_idx;
    logic       report_valid;

    int n_vec  = 0;
    int n_miss = 0;

    rocev2_top_hls_deadlock_report_ctrl #(
        .PROC_NUM(4), .IDX_W(2), .CONFIRM_ROUNDS(4), .TIMEOUT(64)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .dl_detect_vec  (dl_detect_vec),
        .clear_report   (clear_report),
        .dl_detect_in   (dl_detect_in),
        .origin_vec     (origin_vec),
        .token_clear    (token_clear),
        .deadlock_found (deadlock_found),
        .deadlock_idx   (deadlock_idx),
        .report_valid   (report_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge and settle just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; dl_detect_vec = 4'b0000; clear_report = 1'b0;
        cyc(); cyc();
        n_vec++;
        if ({dl_detect_in, origin_vec, token_clear, deadlock_found, deadlock_idx, report_valid} !== 10'b0) begin
            n_miss++;
            $display("FAIL reset_outputs: got %b required 0",
                     {dl_detect_in, origin_vec, token_clear, deadlock_found, deadlock_idx, report_valid});
        end
        reset = 1'b0;
        cyc();
        $display("tx reset: outputs idle");
    endtask

    task automatic test_origin_latency();
        dl_detect_vec = 4'b0110;
        cyc();
        dl_detect_vec = 4'b0000;
        n_vec++;
        if (origin_vec !== 4'b0010) begin
            n_miss++; $display("FAIL origin_lowest: got %b required 0010", origin_vec);
        end
        n_vec++;
        if (dl_detect_in !== 1'b1) begin
            n_miss++; $display("FAIL origin_dl_in: got %b required 1", dl_detect_in);
        end
        cyc();
        n_vec++;
        if (origin_vec !== 4'b0000) begin
            n_miss++; $display("FAIL origin_one_cycle: got %b required 0000", origin_vec);
        end
        // Let it lapse back to IDLE.
        for (int i = 0; i < 64; i++) cyc();
        n_vec++;
        if (dl_detect_in !== 1'b0) begin
            n_miss++; $display("FAIL origin_cleanup: got %b required 0", dl_detect_in);
        end
        $display("tx origin_latency: vec=0110 origin=0010");
    endtask

    task automatic test_persistent_deadlock();
        int strobes;
        strobes = 0;
        dl_detect_vec = 4'b0010;
        cyc();
        dl_detect_vec = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (origin_vec == 4'b0010) strobes++;
            cyc();
            // Other units asserting must not trigger a token kill.
            dl_detect_vec = 4'b1101;
            #1;
            n_vec++;
            if (token_clear !== 1'b0) begin
                n_miss++; $display("FAIL persist_other_bits r%0d: got %b required 0", r, token_clear);
            end
            cyc();
            dl_detect_vec = 4'b0000;
            cyc();
            dl_detect_vec = 4'b0010;
            #1;
            n_vec++;
            if (token_clear !== 1'b1 || report_valid !== 1'b0) begin
                n_miss++;
                $display("FAIL persist_return r%0d: got tc=%b rv=%b required tc=1 rv=0", r, token_clear, report_valid);
            end
            cyc();
            dl_detect_vec = 4'b0000;
            $display("tx persist round %0d: token returned", r);
        end
        n_vec++;
        if (strobes !== 4) begin
            n_miss++; $display("FAIL persist_strobes: got %0d required 4", strobes);
        end
        n_vec++;
        if (report_valid !== 1'b1 || deadlock_found !== 1'b1 || deadlock_idx !== 2'd1 || origin_vec !== 4'b0000) begin
            n_miss++;
            $display("FAIL persist_report: got rv=%b df=%b idx=%0d ov=%b required 1 1 1 0000",
                     report_valid, deadlock_found, deadlock_idx, origin_vec);
        end
        cyc();
        n_vec++;
        if (report_valid !== 1'b0 || deadlock_found !== 1'b1) begin
            n_miss++;
            $display("FAIL persist_pulse: got rv=%b df=%b required rv=0 df=1", report_valid, deadlock_found);
        end
    endtask

    task automatic test_report_hold();
        logic [3:0] pats [3];
        pats[0] = 4'b1111; pats[1] = 4'b0101; pats[2] = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            dl_detect_vec = pats[i];
            #1;
            n_vec++;
            if ({dl_detect_in, origin_vec, token_clear, deadlock_found, deadlock_idx, report_valid} !== 10'b1_0000_0_1_01_0) begin
                n_miss++;
                $display("FAIL report_hold p%0d: got %b required 1000001010", i,
                         {dl_detect_in, origin_vec, token_clear, deadlock_found, deadlock_idx, report_valid});
            end
            cyc();
        end
        dl_detect_vec = 4'b0000;
        clear_report  = 1'b1;
        cyc();
        clear_report  = 1'b0;
        n_vec++;
        if (deadlock_found !== 1'b0 || dl_detect_in !== 1'b0 || deadlock_idx !== 2'd0) begin
            n_miss++;
            $display("FAIL report_clear: got df=%b dl=%b idx=%0d required 0 0 0", deadlock_found, dl_detect_in, deadlock_idx);
        end
        clear_report = 1'b1;
        cyc();
        clear_report = 1'b0;
        n_vec++;
        if (deadlock_found !== 1'b0 || dl_detect_in !== 1'b0 || origin_vec !== 4'b0000) begin
            n_miss++;
            $display("FAIL idle_clear: got df=%b dl=%b ov=%b required 0 0 0000", deadlock_found, dl_detect_in, origin_vec);
        end
        $display("tx report_hold: held then cleared");
    endtask

    task automatic test_timeout();
        int n;
        dl_detect_vec = 4'b1000;
        cyc();
        dl_detect_vec = 4'b0000;
        n_vec++;
        if (origin_vec !== 4'b1000) begin
            n_miss++; $display("FAIL timeout_origin: got %b required 1000", origin_vec);
        end
        cyc();
        n = 0;
        while (dl_detect_in === 1'b1 && n < 200) begin
            n++;
            cyc();
        end
        n_vec++;
        if (n !== 64 || deadlock_found !== 1'b0) begin
            n_miss++; $display("FAIL timeout_len: got %0d cycles df=%b required 64 df=0", n, deadlock_found);
        end
        $display("tx timeout: %0d wait cycles", n);
    endtask

    task automatic test_return_on_timeout();
        dl_detect_vec = 4'b0100;
        cyc();
        dl_detect_vec = 4'b0000;
        cyc();
        for (int i = 0; i < 63; i++) cyc();
        dl_detect_vec = 4'b0100;
        #1;
        n_vec++;
        if (token_clear !== 1'b1) begin
            n_miss++; $display("FAIL edge_return_tc: got %b required 1", token_clear);
        end
        cyc();
        dl_detect_vec = 4'b0000;
        n_vec++;
        if (origin_vec !== 4'b0100 || dl_detect_in !== 1'b1) begin
            n_miss++; $display("FAIL edge_return_round: got ov=%b dl=%b required 0100 1", origin_vec, dl_detect_in);
        end
        for (int i = 0; i < 65; i++) cyc();
        n_vec++;
        if (dl_detect_in !== 1'b0) begin
            n_miss++; $display("FAIL edge_return_cleanup: got %b required 0", dl_detect_in);
        end
        $display("tx return_on_timeout: counted as round");
    endtask

    task automatic test_reset_mid_wait();
        dl_detect_vec = 4'b0001;
        cyc();
        for (int r = 0; r < 2; r++) begin
            dl_detect_vec = 4'b0000;
            cyc();
            dl_detect_vec = 4'b0001;
            cyc();
        end
        dl_detect_vec = 4'b0000;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        n_vec++;
        if ({dl_detect_in, origin_vec, token_clear, deadlock_found, report_valid} !== 8'b0) begin
            n_miss++;
            $display("FAIL reset_mid_wait: got %b required 0",
                     {dl_detect_in, origin_vec, token_clear, deadlock_found, report_valid});
        end
        cyc();
        n_vec++;
        if (dl_detect_in !== 1'b0) begin
            n_miss++; $display("FAIL reset_stays_idle: got %b required 0", dl_detect_in);
        end
        $display("tx reset_mid_wait: back to idle");
    endtask

    initial begin
        test_reset();
        test_origin_latency();
        test_persistent_deadlock();
        test_report_hold();
        test_timeout();
        test_return_on_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rocev2_top_hls_deadlock_report_ctrl.md
Name: rocev2_top_hls_deadlock_report_ctrl

Overview:
- Central controller downstream of the per-process deadlock detection units in the rocev2 dataflow region.
- Collects every unit's dl_detect_out and selects one suspect process as token origin.
- Broadcasts dl_detect_in, circulates the confirmation token, and clears it on return.
- Raises a sticky deadlock report after CONFIRM_ROUNDS consecutive successful token round trips.

Parameters:
- PROC_NUM, 4, number of dataflow processes and detection units.
- IDX_W, 2, width of the process index; must satisfy 2^IDX_W >= PROC_NUM.
- CONFIRM_ROUNDS, 4, consecutive token returns required before a report (range 1..15).
- TIMEOUT, 64, maximum cycles to wait for the token to return (range 2..255).

Ports:
- clock  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dl_detect_vec  in  PROC_NUM  bit i is dl_detect_out of unit i.
- clear_report  in  1  clears a latched report; ignored outside REPORT.
- dl_detect_in  out  1  broadcast to all units; asserted whenever state != IDLE.
- origin_vec  out  PROC_NUM  one-hot origin strobe to the units.
- token_clear  out  1  broadcast token kill.
- deadlock_found  out  1  sticky deadlock flag.
- deadlock_idx  out  IDX_W  index of the process reported in deadlock.
- report_valid  out  1  one-cycle pulse when a report is latched.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE, rounds=0, tmo=0, idx=0.
  - All outputs 0 on the first edge with reset=1.
  - Reset overrides every other input, including mid-round and in REPORT.
- States: IDLE, ORIGIN, WAIT, REPORT. State and counters are registered.
- dl_detect_in = (state != IDLE).
- origin_vec = (state==ORIGIN) ? (1<<idx) : 0.
- token_clear (combinational) = (state==WAIT) & dl_detect_vec[idx].
  - Asserts in the same cycle as the returning dl_detect_out, which the units require.
- IDLE:
  - If |dl_detect_vec: idx <= lowest set bit index; rounds <= 0; go to ORIGIN.
  - Several bits set at once: lowest index wins; the others are ignored.
- ORIGIN: lasts exactly 1 cycle; tmo <= 0; go to WAIT.
  - Latency: detect seen at edge t gives origin_vec high during cycle t+1.
- WAIT: tmo increments every cycle (saturates at TIMEOUT).
  - Token return (dl_detect_vec[idx]=1):
    - If rounds+1 == CONFIRM_ROUNDS: deadlock_idx <= idx; deadlock_found <= 1; report_valid <= 1 for one cycle; go to REPORT.
    - Otherwise: rounds <= rounds+1; go to ORIGIN to launch another round.
  - Timeout (no return and tmo == TIMEOUT-1): deadlock dissolved; rounds <= 0; go to IDLE.
    - dl_detect_in drops the next cycle, so the units resume normal dependence tracking.
  - Return and timeout in the same cycle: return wins.
  - dl_detect_vec bits other than idx are ignored in WAIT and ORIGIN.
- REPORT:
  - dl_detect_in stays 1, which freezes the units' dependence registers.
  - origin_vec=0 and token_clear=0.
  - deadlock_found and deadlock_idx hold.
  - On clear_report=1: deadlock_found <= 0; deadlock_idx <= 0; go to IDLE.
  - A fresh detection may start in the cycle after return to IDLE.
- clear_report outside REPORT has no effect.
- Counter widths: rounds 4 bits, tmo 8 bits. Neither wraps (bounded by the parameter ranges).

Test Plan:
- Reset mid-WAIT (rounds=2) -> next cycle: state IDLE, dl_detect_in=0, origin_vec=0, deadlock_found=0.
- dl_detect_vec=4'b0110 at edge t -> origin_vec=4'b0010 during t+1, dl_detect_in=1 from t+1.
- Persistent deadlock (dl_detect_vec[1] pulses 3 cycles after each origin), CONFIRM_ROUNDS=4:
  - 4 origin strobes, token_clear coincident with each return.
  - report_valid single pulse after the 4th return; deadlock_found=1; deadlock_idx=1.
- Token never returns after the first origin -> 64 cycles in WAIT, then IDLE, dl_detect_in=0, deadlock_found=0.
- Return arriving exactly on the timeout cycle (tmo=63) -> counted as a round, not a timeout.
- In REPORT: toggle dl_detect_vec -> outputs unchanged.
  - Then clear_report=1 -> deadlock_found=0 and IDLE next cycle.
  - clear_report=1 while in IDLE -> no change.
